// File: rtl/mc_pkg.sv
// Shared types, geometry constants and pixel helpers for the streaming
// motion-compensation row engine.
package mc_pkg;

    localparam int unsigned MB_SIZE     = 4;
    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned FRAME_W     = 16;
    localparam int unsigned FRAME_H     = 16;
    localparam int unsigned MV_WIDTH    = 6;

    localparam int unsigned COL_W    = $clog2(FRAME_W);
    localparam int unsigned ROW_W    = $clog2(FRAME_H);
    localparam int unsigned MB_IDX_W = $clog2(MB_SIZE);
    localparam int unsigned RES_W    = PIXEL_WIDTH + 1;
    localparam int unsigned DIM_W    = (COL_W > ROW_W) ? COL_W : ROW_W;
    // Signed coordinate width: wide enough that mb + mv + offset never wraps.
    localparam int unsigned CW       = ((MV_WIDTH > DIM_W) ? MV_WIDTH : DIM_W) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_t;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic signed [RES_W-1:0] residual_t;

    function automatic logic [CW-1:0] clamp_coord(input logic signed [CW-1:0] v,
                                                  input logic signed [CW-1:0] hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic pixel_t frame_px(input logic [FRAME_W*PIXEL_WIDTH-1:0] r,
                                        input logic [COL_W-1:0] c);
        return r[int'(c)*PIXEL_WIDTH +: PIXEL_WIDTH];
    endfunction

    function automatic pixel_t mb_px(input logic [MB_SIZE*PIXEL_WIDTH-1:0] r,
                                     input logic [MB_IDX_W-1:0] j);
        return r[int'(j)*PIXEL_WIDTH +: PIXEL_WIDTH];
    endfunction

    function automatic residual_t sub_px(input pixel_t a, input pixel_t b);
        return residual_t'({1'b0, a}) - residual_t'({1'b0, b});
    endfunction

endpackage

// File: rtl/mc_row_sub.sv
// Column clamp/select from one reference frame row and per-pixel residual.
module mc_row_sub
    import mc_pkg::*;
(
    input  logic [FRAME_W*PIXEL_WIDTH-1:0] ref_row,
    input  logic [MB_SIZE*PIXEL_WIDTH-1:0] cur_row,
    input  logic signed [CW-1:0]           col_base,
    output logic [MB_SIZE*RES_W-1:0]       res_c
);

    always_comb begin
        res_c = '0;
        for (int j = 0; j < MB_SIZE; j++) begin
            res_c[j*RES_W +: RES_W] = sub_px(
                mb_px(cur_row, MB_IDX_W'(j)),
                frame_px(ref_row, COL_W'(clamp_coord(col_base + $signed(CW'(j)),
                                                     $signed(CW'(FRAME_W - 1))))));
        end
    end

endmodule

// File: rtl/mc_row_stream.sv
// Handshaked motion-compensation engine: fetches one clamped reference row per
// step and emits a signed residual row per current-MB row.
module mc_row_stream
    import mc_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [COL_W-1:0]               mb_x,
    input  logic [ROW_W-1:0]               mb_y,
    input  logic [MV_WIDTH-1:0]            mv_x,
    input  logic [MV_WIDTH-1:0]            mv_y,
    output logic                           ref_rd_en,
    output logic [ROW_W-1:0]               ref_rd_row,
    input  logic [FRAME_W*PIXEL_WIDTH-1:0] ref_rd_data,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    input  logic [MB_SIZE*PIXEL_WIDTH-1:0] cur_row,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [MB_SIZE*RES_W-1:0]       res_row,
    output logic                           res_last,
    output logic                           busy
);

    state_t                      state, state_n;
    logic [MB_IDX_W-1:0]         row_idx, row_n;
    logic [COL_W-1:0]            mb_x_q, mb_x_n;
    logic [ROW_W-1:0]            mb_y_q, mb_y_n;
    logic signed [MV_WIDTH-1:0]  mv_x_q, mv_x_n;
    logic signed [MV_WIDTH-1:0]  mv_y_q, mv_y_n;
    logic [FRAME_W*PIXEL_WIDTH-1:0] ref_q, ref_sel;
    logic                        first_calc;
    logic                        res_valid_n, res_last_n;
    logic [MB_SIZE*RES_W-1:0]    res_row_n, res_c;
    logic signed [CW-1:0]        row_sum, col_base;
    logic [ROW_W-1:0]            rd_row_n;

    // Memory data is live only in the first CALC cycle; afterwards use the copy.
    assign ref_sel  = first_calc ? ref_rd_data : ref_q;
    assign col_base = $signed(CW'(mb_x_q)) + CW'(mv_x_q);

    mc_row_sub u_sub (
        .ref_row  (ref_sel),
        .cur_row  (cur_row),
        .col_base (col_base),
        .res_c    (res_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            row_idx     <= '0;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            ref_q       <= '0;
            first_calc  <= 1'b0;
            res_valid   <= 1'b0;
            res_row     <= '0;
            res_last    <= 1'b0;
            start_ready <= 1'b1;
            cur_ready   <= 1'b0;
            ref_rd_en   <= 1'b0;
            ref_rd_row  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            row_idx     <= row_n;
            mb_x_q      <= mb_x_n;
            mb_y_q      <= mb_y_n;
            mv_x_q      <= mv_x_n;
            mv_y_q      <= mv_y_n;
            first_calc  <= (state == READ);
            if (first_calc)
                ref_q <= ref_rd_data;
            res_valid   <= res_valid_n;
            res_row     <= res_row_n;
            res_last    <= res_last_n;
            start_ready <= (state_n == IDLE);
            cur_ready   <= (state_n == CALC);
            ref_rd_en   <= (state_n == READ);
            if (state_n == READ)
                ref_rd_row <= rd_row_n;
            busy        <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        row_n       = row_idx;
        mb_x_n      = mb_x_q;
        mb_y_n      = mb_y_q;
        mv_x_n      = mv_x_q;
        mv_y_n      = mv_y_q;
        res_valid_n = res_valid;
        res_row_n   = res_row;
        res_last_n  = res_last;

        case (state)
            IDLE: begin
                if (start_valid) begin
                    mb_x_n  = mb_x;
                    mb_y_n  = mb_y;
                    mv_x_n  = mv_x;
                    mv_y_n  = mv_y;
                    row_n   = '0;
                    state_n = READ;
                end
            end
            READ: state_n = CALC;
            CALC: begin
                if (cur_valid) begin
                    res_row_n   = res_c;
                    res_last_n  = (row_idx == MB_IDX_W'(MB_SIZE - 1));
                    res_valid_n = 1'b1;
                    state_n     = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    res_last_n  = 1'b0;
                    if (res_last) begin
                        state_n = IDLE;
                    end else begin
                        row_n   = row_idx + MB_IDX_W'(1);
                        state_n = READ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Address of the row about to be read, from the values READ will see.
        row_sum  = $signed(CW'(mb_y_n)) + CW'(mv_y_n) + $signed(CW'(row_n));
        rd_row_n = ROW_W'(clamp_coord(row_sum, $signed(CW'(FRAME_H - 1))));
    end

endmodule

// File: tb/tb_mc_row_stream.sv
// Directed bench for mc_row_stream over a 16x16 frame with ref[r][c] = r*16+c.
module tb_mc_row_stream;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [3:0]   mb_x = '0, mb_y = '0;
    logic [5:0]   mv_x = '0, mv_y = '0;
    logic         ref_rd_en;
    logic [3:0]   ref_rd_row;
    logic [127:0] ref_rd_data = '0;
    logic         cur_valid = 1'b0;
    logic         cur_ready;
    logic [31:0]  cur_row = '0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [35:0]  res_row;
    logic         res_last;
    logic         busy;

    int errors = 0;
    int checks = 0;

    mc_row_stream dut (
        .clk (clk), .reset_n (reset_n),
        .start_valid (start_valid), .start_ready (start_ready),
        .mb_x (mb_x), .mb_y (mb_y), .mv_x (mv_x), .mv_y (mv_y),
        .ref_rd_en (ref_rd_en), .ref_rd_row (ref_rd_row), .ref_rd_data (ref_rd_data),
        .cur_valid (cur_valid), .cur_ready (cur_ready), .cur_row (cur_row),
        .res_valid (res_valid), .res_ready (res_ready), .res_row (res_row),
        .res_last (res_last), .busy (busy)
    );

    always #5 clk = ~clk;

    // Reference frame memory with one-cycle read latency.
    always @(posedge clk) begin
        if (ref_rd_en)
            for (int c = 0; c < 16; c++)
                ref_rd_data[c*8 +: 8] <= 8'(int'(ref_rd_row) * 16 + c);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic start_block(input int bx, input int by, input int vx, input int vy);
        mb_x = 4'(bx); mb_y = 4'(by); mv_x = 6'(vx); mv_y = 6'(vy);
        start_valid = 1'b1;
        check("start_ready_idle", 64'(start_ready), 64'd1);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // Runs one row from its READ cycle through the output handshake.
    task automatic run_row(input string tag, input int exp_rd, input logic [35:0] exp_res,
                           input logic exp_last, input int cur_stall, input int res_stall,
                           input bit overlap);
        int n;
        int lat;
        n = 0;
        while (!ref_rd_en && n < 20) begin @(negedge clk); n++; end
        check({tag, "_rd_en"}, 64'(ref_rd_en), 64'd1);
        check({tag, "_rd_row"}, 64'(ref_rd_row), 64'(exp_rd));
        check({tag, "_start_rdy_busy"}, 64'(start_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        start_valid = 1'b0;
        if (cur_stall > 0) cur_valid = 1'b0;
        if (res_stall > 0) res_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        for (int k = 0; k < cur_stall; k++) begin
            check({tag, "_stall_cur_ready"}, 64'(cur_ready), 64'd1);
            check({tag, "_stall_no_rd"}, 64'(ref_rd_en), 64'd0);
            check({tag, "_stall_no_res"}, 64'(res_valid), 64'd0);
            @(negedge clk);
            lat++;
        end
        cur_valid = 1'b1;
        n = 0;
        while (!res_valid && n < 20) begin @(negedge clk); n++; lat++; end
        check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(2 + cur_stall));
        check({tag, "_res_row"}, 64'(res_row), 64'(exp_res));
        check({tag, "_res_last"}, 64'(res_last), 64'(exp_last));
        check({tag, "_out_cur_ready"}, 64'(cur_ready), 64'd0);
        for (int k = 0; k < res_stall; k++) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_bp_row"}, 64'(res_row), 64'(exp_res));
            check({tag, "_bp_last"}, 64'(res_last), 64'(exp_last));
            check({tag, "_bp_no_rd"}, 64'(ref_rd_en), 64'd0);
            check({tag, "_bp_cur_ready"}, 64'(cur_ready), 64'd0);
        end
        res_ready = 1'b1;
        if (overlap) start_valid = 1'b1;
        @(negedge clk);
        check({tag, "_res_drop"}, 64'(res_valid), 64'd0);
        if (exp_last) begin
            check({tag, "_end_busy"}, 64'(busy), 64'd0);
            check({tag, "_end_start_ready"}, 64'(start_ready), 64'd1);
        end
    endtask

    logic [35:0] t1 [4];

    initial begin
        t1[0] = pack4(-1, -2, -3, -4);
        t1[1] = pack4(-17, -18, -19, -20);
        t1[2] = pack4(-33, -34, -35, -36);
        t1[3] = pack4(-49, -50, -51, -52);

        #12;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_cur_ready", 64'(cur_ready), 64'd0);
        check("rst_rd_en", 64'(ref_rd_en), 64'd0);
        check("rst_res_row", 64'(res_row), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cur_valid = 1'b1;
        @(negedge clk);

        // Interior motion vector
        cur_row = {4{8'd100}};
        start_block(4, 4, 1, 2);
        for (int r = 0; r < 4; r++)
            run_row($sformatf("int_r%0d", r), 6 + r, t1[r], r == 3, 0, 0, 1'b0);

        // Same block with current-row stall and output backpressure
        start_block(4, 4, 1, 2);
        run_row("stl_r0", 6, t1[0], 1'b0, 0, 0, 1'b0);
        run_row("stl_r1", 7, t1[1], 1'b0, 4, 0, 1'b0);
        run_row("stl_r2", 8, t1[2], 1'b0, 0, 5, 1'b0);
        run_row("stl_r3", 9, t1[3], 1'b1, 0, 0, 1'b0);

        // Negative clamp; the next start is presented with the final handshake
        cur_row = '0;
        start_block(0, 0, -3, -2);
        run_row("neg_r0", 0, 36'd0, 1'b0, 0, 0, 1'b0);
        run_row("neg_r1", 0, 36'd0, 1'b0, 0, 0, 1'b0);
        run_row("neg_r2", 0, 36'd0, 1'b0, 0, 0, 1'b0);
        mb_x = 4'd12; mb_y = 4'd12; mv_x = 6'd5; mv_y = 6'd5;
        run_row("neg_r3", 1, pack4(-16, -16, -16, -16), 1'b1, 0, 0, 1'b1);

        // Positive clamp, started from the held start_valid
        @(negedge clk);
        for (int r = 0; r < 4; r++)
            run_row($sformatf("pos_r%0d", r), 15, pack4(-255, -255, -255, -255),
                    r == 3, 0, 0, 1'b0);

        // Reset in the middle of row 2
        cur_row = {4{8'd100}};
        start_block(4, 4, 1, 2);
        run_row("rst_r0", 6, t1[0], 1'b0, 0, 0, 1'b0);
        run_row("rst_r1", 7, t1[1], 1'b0, 0, 0, 1'b0);
        begin
            int n;
            n = 0;
            while (!ref_rd_en && n < 20) begin @(negedge clk); n++; end
        end
        check("rst_mid_rd_en", 64'(ref_rd_en), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_res_valid", 64'(res_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_start_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_res", 64'(res_valid), 64'd0);
            check("post_rst_idle", 64'(busy), 64'd0);
        end
        start_block(4, 4, 1, 2);
        for (int r = 0; r < 4; r++)
            run_row($sformatf("again_r%0d", r), 6 + r, t1[r], r == 3, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_row_stream.md
Name: mc_row_stream

Overview:
- Streaming, handshaked successor to the single-cycle 4x4 motion compensation block.
- Takes a macroblock position and a signed motion vector, and fetches one reference row per step from a frame-row memory port.
- Clamps out-of-frame coordinates by edge replication (unrestricted MV).
- Subtracts each reference row from the incoming current-MB row and emits signed residual rows with valid/ready.
- Sits between the motion estimator (MV source) and the forward transform.

Parameters:
- MB_SIZE, 4: macroblock edge in pixels.
- PIXEL_WIDTH, 8: unsigned pixel width.
- FRAME_W, 16: reference frame width in pixels.
- FRAME_H, 16: reference frame height in pixels.
- MV_WIDTH, 6: signed two's-complement MV component width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  block request valid.
- start_ready  out  1  block accepted when both high.
- mb_x  in  $clog2(FRAME_W)  MB top-left column.
- mb_y  in  $clog2(FRAME_H)  MB top-left row.
- mv_x  in  MV_WIDTH  signed horizontal MV.
- mv_y  in  MV_WIDTH  signed vertical MV.
- ref_rd_en  out  1  reference row read strobe.
- ref_rd_row  out  $clog2(FRAME_H)  reference row index.
- ref_rd_data  in  FRAME_W*PIXEL_WIDTH  full frame row; pixel c at bits [c*PW +: PW]; valid exactly 1 cycle after ref_rd_en.
- cur_valid  in  1  current-MB row valid.
- cur_ready  out  1  current row consumed when both high.
- cur_row  in  MB_SIZE*PIXEL_WIDTH  current-MB row, pixel j at [j*PW +: PW].
- res_valid  out  1  residual row valid.
- res_ready  in  1  downstream accepts.
- res_row  out  MB_SIZE*(PIXEL_WIDTH+1)  signed residual row.
- res_last  out  1  marks row MB_SIZE-1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state IDLE, row counter 0, all outputs 0 except start_ready=1; captured mb/mv cleared.
- FSM IDLE -> READ -> CALC -> OUT:
  - IDLE: start_ready=1. On start_valid, capture mb_x/mb_y/mv_x/mv_y, set row i=0, go to READ.
  - READ: one cycle. ref_rd_en=1, ref_rd_row = clamp(mb_y + mv_y + i, 0, FRAME_H-1). Go to CALC.
  - CALC: register ref_rd_data on entry, so the row holds across waits. cur_ready=1. On cur_valid, load res_row[j] = cur_row[j] - ref[clamp(mb_x + mv_x + j, 0, FRAME_W-1)] for each j independently. Set res_valid=1, res_last=(i==MB_SIZE-1), go to OUT.
  - OUT: hold res_row and res_last stable while res_valid && !res_ready. On handshake, res_valid=0. If last, go to IDLE; else i++ and go to READ.
- Arithmetic:
  - Coordinate sums are computed signed, at least max(MV_WIDTH, log2 dim)+2 bits wide, with no wrap.
  - Residual is PIXEL_WIDTH+1-bit two's complement, range -255..255 at PW=8, never saturated.
- Handshake rules:
  - cur_ready is 0 outside CALC; cur_valid is ignored there.
  - start_ready is 0 outside IDLE.
  - ref_rd_en never asserts in OUT.
- Throughput: minimum 3 cycles per row, 12 cycles per 4x4 MB with no stalls. First res_valid appears 3 cycles after the start handshake when cur_valid is held high.
- A start_valid and a final res handshake in the same cycle: the start is taken on the following IDLE cycle, not the same one.
- Reset mid-block abandons the block immediately. No partial residual is emitted afterwards.

Decomposition:
- Package mc_pkg:
  - state enum (IDLE, READ, CALC, OUT).
  - pixel_t and residual_t typedefs.
  - clamp_coord function (signed value, upper bound).
  - row-pack/unpack helper functions.
- Sub-module mc_row_sub (combinational): column clamp/select from the registered frame row, plus per-pixel subtraction. Instantiated once; the top holds the FSM and registers.

Test Plan:
- Common setup: FRAME 16x16, ref[r][c] = r*16+c.
1. Interior MV: mb(4,4), mv(+1,+2), cur all 100 -> row0 residual = -1,-2,-3,-4 (9'h1FF,1FE,1FD,1FC); row3 = -49..-52; res_last only on the 4th row.
2. Negative clamp: mb(0,0), mv(-3,-2), cur all 0 -> ref rows read 0,0,0,1; rows0-2 residual 0; row3 = -16 for every pixel.
3. Positive clamp: mb(12,12), mv(+5,+5), cur all 0 -> every ref pixel 255; all residuals -255 (9'h101); ref_rd_row = 15 every read.
4. Backpressure: res_ready low 5 cycles in OUT -> res_valid stays 1, res_row stable, no ref_rd_en, cur_ready 0; the row completes on release.
5. cur stall: cur_valid low 4 cycles in CALC -> state holds, no second ref read; correct residual when cur_valid rises.
6. Reset mid-block: reset_n low during row 2 -> res_valid=0, busy=0, start_ready=1 immediately; a new start afterwards produces a correct 4-row block.
